mult_8x8_seq_ctrl: RTL and testbench

Sequencing controller that computes an 8x8 product by time-sharing one external 4x4 approximate sub-multiplier (LM-type) over four quadrant passes: LL, LH, HL, HH. It latches operands via a valid/ready handshake, drives the shared unit with nibble operands and a per-quadrant approximation mode, and shift-accumulates the 8-bit partial products. It sits in front of the shared LM instance and replaces four parallel sub-multipliers, trading latency for area.

---
 rtl/mult_8x8_seq_ctrl_if.sv | 25 ++
 rtl/mult_8x8_seq_ctrl.sv | 69 ++++++
 tb/tb_mult_8x8_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_8x8_seq_ctrl_if.sv
// mult_8x8_seq_ctrl_if: operand/result handshake and shared sub-multiplier bus
interface mult_8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        sub_en;
  logic [3:0]  sub_A;
  logic [3:0]  sub_B;
  logic [1:0]  sub_mode;
  logic [7:0]  sub_R;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic        ovf;
  logic        busy;
  modport master (
    output in_valid, A, B, sub_R, out_ready,
    input  in_ready, sub_en, sub_A, sub_B, sub_mode, out_valid, R, ovf, busy
  );
  modport slave (
    input  in_valid, A, B, sub_R, out_ready,
    output in_ready, sub_en, sub_A, sub_B, sub_mode, out_valid, R, ovf, busy
  );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl: 8x8 product via four time-shared 4x4 sub-multiplier passes
module mult_8x8_seq_ctrl #(
  parameter logic [1:0] MODE_LL = 2'd3,
  parameter logic [1:0] MODE_LH = 2'd1,
  parameter logic [1:0] MODE_HL = 2'd1,
  parameter logic [1:0] MODE_HH = 2'd1
) (
  input logic clk,
  input logic rst,
  mult_8x8_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state, state_nxt;
  logic [1:0]  q;
  logic [7:0]  a_r, b_r;
  logic [16:0] acc, acc_nxt;
  logic [15:0] r_q;
  logic        ovf_q;
  logic        accept, calc;
  logic [3:0]  shift;
  assign calc          = state == CALC;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.sub_en    = calc;
  assign bus.sub_A     = calc ? (q[1] ? a_r[7:4] : a_r[3:0]) : 4'd0;
  assign bus.sub_B     = calc ? (q[0] ? b_r[7:4] : b_r[3:0]) : 4'd0;
  assign bus.sub_mode  = !calc ? 2'd0 : q == 2'd0 ? MODE_LL : q == 2'd1 ? MODE_LH : q == 2'd2 ? MODE_HL : MODE_HH;
  assign bus.R         = r_q;
  assign bus.ovf       = ovf_q;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state, accept strobe and exact shifted accumulation of the current quadrant
  always_comb begin
    accept    = bus.in_valid && state == IDLE;
    shift     = q == 2'd0 ? 4'd0 : q == 2'd3 ? 4'd8 : 4'd4;
    acc_nxt   = acc + ({9'd0, bus.sub_R} << shift);
    state_nxt = state;
    if (accept) state_nxt = (bus.A == 8'd0 || bus.B == 8'd0) ? DONE : CALC;
    if (calc && q == 2'd3) state_nxt = DONE;
    if (state == DONE && bus.out_ready) state_nxt = IDLE;
  end
  // operand latch, quadrant counter, accumulator and saturated result
  always_ff @(posedge clk)
    if (rst) begin
      q     <= 2'd0;
      a_r   <= 8'd0;
      b_r   <= 8'd0;
      acc   <= 17'd0;
      r_q   <= 16'd0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      q     <= 2'd0;
      a_r   <= bus.A;
      b_r   <= bus.B;
      acc   <= 17'd0;
      r_q   <= 16'd0;
      ovf_q <= 1'b0;
    end else if (calc) begin
      acc <= acc_nxt;
      q   <= q + 2'd1;
      if (q == 2'd3) begin
        r_q   <= acc_nxt[16] ? 16'hFFFF : acc_nxt[15:0];
        ovf_q <= acc_nxt[16];
      end
    end
endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// tb_mult_8x8_seq_ctrl: scoreboard bench for the sequenced 8x8 multiplier controller
module tb_mult_8x8_seq_ctrl;
  typedef struct {
    logic [15:0] r;
    logic        o;
    int          lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_ff = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [9:0]  sub_log[$];
  logic        prev_ov = 1'b0;
  logic [15:0] held_r = 16'd0;
  logic [1:0]  modes[4] = '{2'd3, 2'd1, 2'd1, 2'd1};
  logic [7:0]  va[7] = '{8'h01, 8'h02, 8'h10, 8'h0F, 8'h20, 8'hFF, 8'h03};
  logic [7:0]  vb[7] = '{8'h01, 8'h03, 8'h10, 8'h11, 8'h08, 8'h01, 8'h05};
  logic [15:0] vr[7] = '{16'h0001, 16'h0006, 16'h0100, 16'h00FF, 16'h0100, 16'h00FF, 16'h000F};
  mult_8x8_seq_ctrl_if bus();
  mult_8x8_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.sub_R = force_ff ? 8'hFF : 8'({4'd0, bus.sub_A} * {4'd0, bus.sub_B});
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.sub_en) sub_log.push_back({bus.sub_A, bus.sub_B, bus.sub_mode});
    if (bus.out_valid) begin
      if (!prev_ov) begin
        held_r = bus.R;
        if (sb.size() > 0) chk("latency", cyc - acc_cyc, sb[0].lat);
      end else chk("r_hold", bus.R, held_r);
      chk("in_ready_done", bus.in_ready, 0);
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got R=%0h want none", bus.R);
        end else begin
          e = sb.pop_front();
          chk("R", bus.R, e.r);
          chk("ovf", bus.ovf, e.o);
        end
      end
    end
    prev_ov = bus.out_valid;
  end
  task automatic accept_only(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        acc_cyc = cyc + 1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = 8'hEE;
    bus.B = 8'hDD;
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r, input logic o, input int lat);
    sb.push_back('{r, o, lat});
    accept_only(a, b);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got pending=%0d want 0", sb.size());
      sb.delete();
    end
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.A = 8'd0;
    bus.B = 8'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {bus.in_ready, bus.out_valid, bus.sub_en, bus.busy, bus.ovf, bus.R, bus.sub_A, bus.sub_B, bus.sub_mode},
        {5'b10000, 16'h0, 10'h0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    sub_log.delete();
    issue(8'hFF, 8'hFF, 16'hFE01, 1'b0, 4);
    wait_done();
    chk("t1_idle", {bus.in_ready, bus.busy}, 2'b10);
    chk("t1_sub_cnt", sub_log.size(), 4);
    for (int i = 0; i < 4 && i < sub_log.size(); i++) chk("t1_sub", sub_log[i], {8'hFF, modes[i]});
    sub_log.delete();
    issue(8'h00, 8'h37, 16'h0000, 1'b0, 0);
    wait_done();
    chk("t2_no_sub", sub_log.size(), 0);
    issue(8'h12, 8'h34, 16'h03A8, 1'b0, 4);
    wait_done();
    force_ff = 1'b1;
    issue(8'h11, 8'h11, 16'hFFFF, 1'b1, 4);
    wait_done();
    force_ff = 1'b0;
    bus.out_ready = 1'b0;
    issue(8'hA5, 8'h3C, 16'h26AC, 1'b0, 4);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done();
    chk("t4_idle", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    accept_only(8'h5A, 8'h3C);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_q2", {bus.sub_en, bus.sub_A, bus.sub_B, bus.sub_mode}, {1'b1, 4'h5, 4'hC, 2'd1});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_rst", {bus.in_ready, bus.out_valid, bus.busy, bus.sub_en, bus.R}, {4'b1000, 16'h0});
    repeat (8) @(posedge clk);
    #1;
    issue(8'h07, 8'h09, 16'h003F, 1'b0, 4);
    wait_done();
    n = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      bus.A = va[i % 7];
      bus.B = vb[i % 7];
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back('{vr[i % 7], 1'b0, 4});
        acc_cyc = cyc + 1;
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("t6_accepts", n, 4);
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
